// File: rtl/jtkcpu_intseq_if.sv
// Push/pull handshake and vector-fetch bus between the interrupt sequencer
// (master) and the push/pull unit plus bus address mux (slave).
interface jtkcpu_intseq_if;
  logic        psh_go;
  logic        pshint;
  logic        pshpul_busy;
  logic        vec_rd;
  logic [15:0] vec_addr;
  logic        vec_lo;
  logic        vec_ok;

  modport master (
    output psh_go, pshint, vec_rd, vec_addr, vec_lo,
    input  pshpul_busy, vec_ok
  );

  modport slave (
    input  psh_go, pshint, vec_rd, vec_addr, vec_lo,
    output pshpul_busy, vec_ok
  );
endinterface

// File: rtl/jtkcpu_intseq.sv
// KCPU interrupt-entry sequencer: priority pick, push, CC mask, vector fetch.
// Optional JTKCPU_NMI_ARM_EN adds s_wr and keeps NMI disarmed until the first write to S.
//
// state  | meaning
// IDLE   | waiting for an instruction boundary with an accepted interrupt
// PUSH   | psh_go issued, waiting for pshpul_busy to rise then fall
// MASK   | one cycle pulsing set_i (and set_f for NMI/FIRQ)
// VEC_HI | reading vector high byte
// VEC_LO | reading vector low byte
// DONE   | load_pc pulse, sequence released
module jtkcpu_intseq #(
  parameter logic [15:0] NMI_VEC  = 16'hFFFC,
  parameter logic [15:0] FIRQ_VEC = 16'hFFF6,
  parameter logic [15:0] IRQ_VEC  = 16'hFFF8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       nmi_n,
  input  logic       firq_n,
  input  logic       irq_n,
  input  logic       cc_i,
  input  logic       cc_f,
  input  logic       insn_end,
  input  logic       cwai,
`ifdef JTKCPU_NMI_ARM_EN
  input  logic       s_wr,
`endif
  output logic       int_busy,
  output logic       set_e,
  output logic       clr_e,
  output logic       set_i,
  output logic       set_f,
  output logic       load_pc,
  output logic [1:0] cause,
  jtkcpu_intseq_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_PUSH, ST_MASK, ST_VEC_HI, ST_VEC_LO, ST_DONE
  } state_t;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_IRQ  = 2'd1;
  localparam logic [1:0] CAUSE_FIRQ = 2'd2;
  localparam logic [1:0] CAUSE_NMI  = 2'd3;

  state_t      state, state_nx;
  logic        nmi_last, nmi_pend, nmi_pend_nx, nmi_fall, nmi_take, nmi_armed;
  logic        psh_issued, psh_issued_nx, busy_seen, busy_seen_nx;
  logic [1:0]  sel, cause_nx;
  logic        busy_nx, set_e_nx, clr_e_nx, set_i_nx, set_f_nx, load_pc_nx;
  logic        psh_go_nx, pshint_nx, vec_rd_nx, vec_lo_nx;
  logic [15:0] vec_addr_nx;

  function automatic logic [15:0] vec_of(input logic [1:0] c);
    case (c)
      CAUSE_NMI:  return NMI_VEC;
      CAUSE_FIRQ: return FIRQ_VEC;
      default:    return IRQ_VEC;
    endcase
  endfunction

`ifdef JTKCPU_NMI_ARM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      nmi_armed <= 1'b0;
    else if (cen && s_wr)
      nmi_armed <= 1'b1;
  end
`else
  assign nmi_armed = 1'b1;
`endif

  // A new edge wins over the clear so an edge during acceptance is not lost
  assign nmi_fall    = nmi_armed & nmi_last & ~nmi_n;
  assign nmi_pend_nx = nmi_fall | (nmi_pend & ~nmi_take);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      nmi_last     <= 1'b1;
      nmi_pend     <= 1'b0;
      psh_issued   <= 1'b0;
      busy_seen    <= 1'b0;
      int_busy     <= 1'b0;
      cause        <= CAUSE_NONE;
      set_e        <= 1'b0;
      clr_e        <= 1'b0;
      set_i        <= 1'b0;
      set_f        <= 1'b0;
      load_pc      <= 1'b0;
      bus.psh_go   <= 1'b0;
      bus.pshint   <= 1'b0;
      bus.vec_rd   <= 1'b0;
      bus.vec_addr <= 16'h0000;
      bus.vec_lo   <= 1'b0;
    end else if (cen) begin
      state        <= state_nx;
      nmi_last     <= nmi_n;
      nmi_pend     <= nmi_pend_nx;
      psh_issued   <= psh_issued_nx;
      busy_seen    <= busy_seen_nx;
      int_busy     <= busy_nx;
      cause        <= cause_nx;
      set_e        <= set_e_nx;
      clr_e        <= clr_e_nx;
      set_i        <= set_i_nx;
      set_f        <= set_f_nx;
      load_pc      <= load_pc_nx;
      bus.psh_go   <= psh_go_nx;
      bus.pshint   <= pshint_nx;
      bus.vec_rd   <= vec_rd_nx;
      bus.vec_addr <= vec_addr_nx;
      bus.vec_lo   <= vec_lo_nx;
    end
  end

  always_comb begin
    sel = CAUSE_NONE;
    if (nmi_pend)               sel = CAUSE_NMI;
    else if (!firq_n && !cc_f)  sel = CAUSE_FIRQ;
    else if (!irq_n && !cc_i)   sel = CAUSE_IRQ;

    state_nx      = state;
    psh_issued_nx = psh_issued;
    busy_seen_nx  = busy_seen;
    busy_nx       = int_busy;
    cause_nx      = cause;
    pshint_nx     = bus.pshint;
    vec_rd_nx     = bus.vec_rd;
    vec_addr_nx   = bus.vec_addr;
    vec_lo_nx     = bus.vec_lo;
    psh_go_nx     = 1'b0;
    set_e_nx      = 1'b0;
    clr_e_nx      = 1'b0;
    set_i_nx      = 1'b0;
    set_f_nx      = 1'b0;
    load_pc_nx    = 1'b0;
    nmi_take      = 1'b0;

    case (state)
      ST_IDLE: begin
        if ((insn_end || cwai) && sel != CAUSE_NONE) begin
          cause_nx = sel;
          busy_nx  = 1'b1;
          nmi_take = (sel == CAUSE_NMI);
          if (cwai) begin
            // CWAI already stacked everything, so go straight to masking
            state_nx = ST_MASK;
            set_i_nx = 1'b1;
            set_f_nx = (sel != CAUSE_IRQ);
          end else begin
            state_nx      = ST_PUSH;
            set_e_nx      = (sel != CAUSE_FIRQ);
            clr_e_nx      = (sel == CAUSE_FIRQ);
            pshint_nx     = 1'b1;
            psh_issued_nx = 1'b0;
            busy_seen_nx  = 1'b0;
          end
        end
      end
      ST_PUSH: begin
        if (!psh_issued) begin
          psh_go_nx     = 1'b1;
          psh_issued_nx = 1'b1;
        end else if (!busy_seen) begin
          if (bus.pshpul_busy) busy_seen_nx = 1'b1;
        end else if (!bus.pshpul_busy) begin
          state_nx  = ST_MASK;
          pshint_nx = 1'b0;
          set_i_nx  = 1'b1;
          set_f_nx  = (cause != CAUSE_IRQ);
        end
      end
      ST_MASK: begin
        state_nx    = ST_VEC_HI;
        vec_rd_nx   = 1'b1;
        vec_addr_nx = vec_of(cause);
        vec_lo_nx   = 1'b0;
      end
      ST_VEC_HI: begin
        if (bus.vec_ok) begin
          state_nx    = ST_VEC_LO;
          vec_addr_nx = bus.vec_addr + 16'd1;
          vec_lo_nx   = 1'b1;
        end
      end
      ST_VEC_LO: begin
        if (bus.vec_ok) begin
          state_nx   = ST_DONE;
          load_pc_nx = 1'b1;
          vec_rd_nx  = 1'b0;
          vec_lo_nx  = 1'b0;
          busy_nx    = 1'b0;
          cause_nx   = CAUSE_NONE;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule
